// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ clients.
// Ports: clk/rst, per-client req_* in, req_ready/rsp_* out, mem_* to memory.
module mem_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic                      rsp_we,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      mem_W_en,
    output logic [ADDR_W-1:0]         mem_Address,
    output logic [DATA_W-1:0]         mem_Data_in,
    input  logic [DATA_W-1:0]         mem_Data_out,
    input  logic                      mem_Valid_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CW    = IDX_W + 1;

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_any;
    logic [IDX_W-1:0]   gnt_id;
    logic [CW-1:0]      pos;

    logic               cmd_v_q;
    logic [IDX_W-1:0]   cmd_id_q;
    logic               cmd_we_q;
    logic [ADDR_W-1:0]  cmd_addr_q;
    logic [DATA_W-1:0]  cmd_wdata_q;

    logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic               rsp_we_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic               rsp_err_q;

    // Scan from the pointer, wrapping, first valid requester wins.
    // Nothing is granted while reset is held.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        pos     = '0;
        gnt     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = {1'b0, ptr_q} + CW'(i);
            if (pos >= CW'(NUM_REQ)) begin
                pos = pos - CW'(NUM_REQ);
            end
            if (!gnt_any && req_valid[pos[IDX_W-1:0]] && rst) begin
                gnt_any = 1'b1;
                gnt_id  = pos[IDX_W-1:0];
            end
        end
        if (gnt_any) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            if (gnt_id == IDX_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_id + 1'b1;
            end
        end
    end

    always_comb begin
        rsp_vld_d = '0;
        if (cmd_v_q) begin
            rsp_vld_d[cmd_id_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            cmd_v_q     <= 1'b0;
            cmd_id_q    <= '0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rsp_vld_q   <= '0;
            rsp_we_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cmd_v_q <= gnt_any;
            if (gnt_any) begin
                cmd_id_q    <= gnt_id;
                cmd_we_q    <= req_we[gnt_id];
                cmd_addr_q  <= req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
                cmd_wdata_q <= req_wdata[int'(gnt_id)*DATA_W +: DATA_W];
            end
            rsp_vld_q <= rsp_vld_d;
            if (cmd_v_q) begin
                rsp_we_q   <= cmd_we_q;
                rsp_data_q <= cmd_we_q ? '0 : mem_Data_out;
                rsp_err_q  <= ~cmd_we_q & ~mem_Valid_out;
            end else begin
                // data and we hold; error is a per-response flag
                rsp_err_q <= 1'b0;
            end
        end
    end

    assign req_ready   = gnt;
    assign mem_W_en    = cmd_v_q & cmd_we_q;
    assign mem_Address = cmd_addr_q;
    assign mem_Data_in = mem_W_en ? cmd_wdata_q : '0;
    assign rsp_valid   = rsp_vld_q;
    assign rsp_we      = rsp_we_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: 16x32 memory, behavioural model, directed tests.
// Model checks every cycle; literal checks pin grant order and data.
module tb_mem_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic            rsp_we, rsp_err;
    logic [DW-1:0]   rsp_data;
    logic            mem_W_en;
    logic [AW-1:0]   mem_Address;
    logic [DW-1:0]   mem_Data_in, mem_Data_out;
    logic            mem_Valid_out;

    mem_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_we(rsp_we), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_W_en(mem_W_en), .mem_Address(mem_Address),
        .mem_Data_in(mem_Data_in), .mem_Data_out(mem_Data_out),
        .mem_Valid_out(mem_Valid_out)
    );

    always #5 clk = ~clk;

    // Memory instance stand-in: sync write, async read, cleared by reset.
    logic [DW-1:0] mem [16];
    logic [15:0]   mvld;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mvld <= '0;
        end else if (mem_W_en) begin
            mem[mem_Address]  <= mem_Data_in;
            mvld[mem_Address] <= 1'b1;
        end
    end
    assign mem_Data_out  = mem[mem_Address];
    assign mem_Valid_out = mvld[mem_Address];

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int          due;
        int          id;
        logic        we;
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        int          id;
        logic        we;
        logic [31:0] data;
        logic        err;
    } obs_t;

    // Model state
    exp_t          q[$];
    int            mptr = 0;
    int            cyc = 0;
    logic [31:0]   mmem [16];
    bit            mmv [16];
    bit            pv = 0, pwe = 0;
    int            paddr = 0;
    logic [31:0]   pwd = 0;

    int   glog[$];
    obs_t rlog[$];

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_we", 32'(rsp_we), 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_err", 32'(rsp_err), 0);
            chk("rst_mem_W_en", 32'(mem_W_en), 0);
            chk("rst_mem_Address", 32'(mem_Address), 0);
            chk("rst_mem_Data_in", mem_Data_in, 0);
            q.delete();
            mptr = 0;
            pv = 0;
            for (int i = 0; i < 16; i++) begin
                mmem[i] = '0;
                mmv[i]  = 0;
            end
        end else begin
            logic [N-1:0] erv;
            exp_t e;
            int g;
            int idx;
            erv = '0;
            e = '{0, 0, 1'b0, 32'h0, 1'b0};
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                erv[e.id] = 1'b1;
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(erv));
            if (erv != 0) begin
                chk("rsp_we", 32'(rsp_we), 32'(e.we));
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end else begin
                chk("rsp_err_idle", 32'(rsp_err), 0);
            end
            if (rsp_valid != 0)
                rlog.push_back('{oh2i(rsp_valid), rsp_we, rsp_data, rsp_err});
            chk("mem_W_en", 32'(mem_W_en), 32'(pv && pwe));
            if (pv) chk("mem_Address", 32'(mem_Address), 32'(paddr));
            chk("mem_Data_in", mem_Data_in, (pv && pwe) ? pwd : 32'h0);
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (mptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
            if (req_ready != 0) glog.push_back(oh2i(req_ready));
            pv = (g >= 0);
            if (pv) begin
                exp_t n;
                pwe   = req_we[g];
                paddr = int'(req_addr[g*AW +: AW]);
                pwd   = req_wdata[g*DW +: DW];
                n.due = cyc + 2;
                n.id  = g;
                n.we  = pwe;
                if (pwe) begin
                    mmem[paddr] = pwd;
                    mmv[paddr]  = 1;
                    n.data = 0;
                    n.err  = 0;
                end else begin
                    n.data = mmem[paddr];
                    n.err  = !mmv[paddr];
                end
                q.push_back(n);
                mptr = (g + 1) % N;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = 1'b1;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    int fair [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int skip [3] = '{3, 1, 3};

    initial begin
        rst = 1'b0;
        clr();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), '0);
        repeat (3) step();

        // fairness from reset release
        rst = 1'b1;
        glog.delete();
        rlog.delete();
        repeat (8) step();
        clr();
        repeat (3) step();
        chk("fair_count", 32'(glog.size()), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++)
            chk("fair_grant", 32'(glog[i]), 32'(fair[i]));
        chk("fair_rsp_count", 32'(rlog.size()), 8);
        for (int i = 0; i < 8 && i < rlog.size(); i++)
            chk("fair_rsp_id", 32'(rlog[i].id), 32'(fair[i]));

        // single write then read
        rlog.delete();
        set_req(0, 1'b1, 4'd3, 32'hDEADBEEF);
        step();
        clr();
        set_req(0, 1'b0, 4'd3, '0);
        step();
        clr();
        repeat (3) step();
        chk("wr_rsp_count", 32'(rlog.size()), 2);
        if (rlog.size() == 2) begin
            chk("wr_ack_id", 32'(rlog[0].id), 0);
            chk("wr_ack_we", 32'(rlog[0].we), 1);
            chk("rd_data", rlog[1].data, 32'hDEADBEEF);
            chk("rd_err", 32'(rlog[1].err), 0);
        end

        // pointer skip: move pointer to 2, then req1/req3 contend
        set_req(1, 1'b0, 4'd5, '0);
        step();
        clr();
        step();
        glog.delete();
        set_req(1, 1'b0, 4'd1, '0);
        set_req(3, 1'b0, 4'd3, '0);
        repeat (3) step();
        clr();
        repeat (3) step();
        chk("skip_count", 32'(glog.size()), 3);
        for (int i = 0; i < 3 && i < glog.size(); i++)
            chk("skip_grant", 32'(glog[i]), 32'(skip[i]));

        // read-after-write across requesters
        rlog.delete();
        set_req(2, 1'b1, 4'd15, 32'h12345678);
        step();
        clr();
        set_req(0, 1'b0, 4'd15, '0);
        step();
        clr();
        repeat (3) step();
        chk("raw_count", 32'(rlog.size()), 2);
        if (rlog.size() == 2) begin
            chk("raw_ack_id", 32'(rlog[0].id), 2);
            chk("raw_rd_id", 32'(rlog[1].id), 0);
            chk("raw_rd_data", rlog[1].data, 32'h12345678);
        end

        // reset one cycle after a read accept
        rlog.delete();
        set_req(1, 1'b0, 4'd3, '0);
        step();
        clr();
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("midrst_no_pulse", 32'(rlog.size()), 0);
        set_req(1, 1'b0, 4'd3, '0);
        step();
        clr();
        repeat (3) step();
        chk("post_rst_count", 32'(rlog.size()), 1);
        if (rlog.size() == 1) begin
            chk("post_rst_data", rlog[0].data, 32'h0);
            chk("post_rst_id", 32'(rlog[0].id), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
